// File: rtl/muldiv_controller_if.sv
// Handshake and data bundle between the execute stage and the RV32M sequencer.
interface muldiv_controller_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, funct3, operand_a, operand_b, kill,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, operand_a, operand_b, kill,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_controller.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply and
// restoring divide on magnitudes, with sign fix-up and RISC-V special cases.
module muldiv_controller (
  input  logic                       clk,
  input  logic                       reset_n,
  muldiv_controller_if.slave         bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_p0;
  logic        sign_a_p0;
  logic        sign_b_p0;
  logic [31:0] mcand_p0;
  logic [63:0] acc_p0;
  logic [5:0]  cnt_p0;
  logic [31:0] result_p1;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    logic signed [31:0] s;
    s = -$signed(v);
    return s;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    logic signed [63:0] s;
    s = -$signed(v);
    return s;
  endfunction

  logic        accept;
  logic        sa_in, sb_in;
  logic [31:0] abs_a, abs_b;
  logic        b_zero, ovf_in, special_in;
  logic [31:0] special_val;

  always_comb begin
    accept      = (state == IDLE) && bus.start && !bus.kill;
    sa_in       = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                  (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    sb_in       = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                  (bus.funct3 == 3'b110);
    abs_a       = (sa_in && bus.operand_a[31]) ? neg32(bus.operand_a) : bus.operand_a;
    abs_b       = (sb_in && bus.operand_b[31]) ? neg32(bus.operand_b) : bus.operand_b;
    b_zero      = (bus.operand_b == 32'd0);
    // Signed division only (funct3 LSB clear): most-negative / -1.
    ovf_in      = !bus.funct3[0] && (bus.operand_a == 32'h8000_0000) &&
                  (bus.operand_b == 32'hFFFF_FFFF);
    special_in  = bus.funct3[2] && (b_zero || ovf_in);
    special_val = 32'd0;
    if (b_zero)
      special_val = bus.funct3[1] ? bus.operand_a : 32'hFFFF_FFFF;
    else
      special_val = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  // One shift-add or restoring-divide step on the shared accumulator.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [33:0] trial;
  logic [63:0] div_next;
  logic [63:0] prod;
  logic [31:0] quo_fix, rem_fix, fix_val;

  always_comb begin
    mul_sum  = {1'b0, acc_p0[63:32]} + {1'b0, mcand_p0};
    mul_next = acc_p0[0] ? {mul_sum, acc_p0[31:1]} : {1'b0, acc_p0[63:1]};
    trial    = {1'b0, acc_p0[63:31]} - {2'b00, mcand_p0};
    div_next = trial[33] ? {acc_p0[62:0], 1'b0}
                         : {trial[31:0], acc_p0[30:0], 1'b1};
    prod     = (sign_a_p0 ^ sign_b_p0) ? neg64(acc_p0) : acc_p0;
    quo_fix  = (sign_a_p0 ^ sign_b_p0) ? neg32(acc_p0[31:0]) : acc_p0[31:0];
    rem_fix  = sign_a_p0 ? neg32(acc_p0[63:32]) : acc_p0[63:32];
    if (op_p0[2])
      fix_val = op_p0[1] ? rem_fix : quo_fix;
    else
      fix_val = (op_p0[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = special_in ? DONE : CALC;
      CALC: begin
        if (bus.kill)               state_nxt = IDLE;
        else if (cnt_p0 == 6'd31)   state_nxt = FIX;
      end
      FIX:  state_nxt = bus.kill ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Accept stage: latch op, signs and magnitudes; iterate in CALC; resolve in FIX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_p0     <= 3'd0;
      sign_a_p0 <= 1'b0;
      sign_b_p0 <= 1'b0;
      mcand_p0  <= 32'd0;
      acc_p0    <= 64'd0;
      cnt_p0    <= 6'd0;
      result_p1 <= 32'd0;
    end else begin
      if (accept) begin
        op_p0     <= bus.funct3;
        sign_a_p0 <= sa_in && bus.operand_a[31];
        sign_b_p0 <= sb_in && bus.operand_b[31];
        cnt_p0    <= 6'd0;
        if (bus.funct3[2]) begin
          mcand_p0 <= abs_b;
          acc_p0   <= {32'd0, abs_a};
        end else begin
          mcand_p0 <= abs_a;
          acc_p0   <= {32'd0, abs_b};
        end
        if (special_in) result_p1 <= special_val;
      end else if (state == CALC && !bus.kill) begin
        acc_p0 <= op_p0[2] ? div_next : mul_next;
        cnt_p0 <= cnt_p0 + 6'd1;
      end else if (state == FIX && !bus.kill) begin
        result_p1 <= fix_val;
      end
    end
  end

  assign bus.busy   = (state == CALC) || (state == FIX);
  assign bus.done   = (state == DONE);
  assign bus.result = result_p1;

endmodule

// File: tb/tb_muldiv_controller.sv
// Scoreboard bench for muldiv_controller: directed RV32M cases, kill, async
// reset and randomized operations against a plain-arithmetic reference model.
module tb_muldiv_controller;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  muldiv_controller_if bus();

  muldiv_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_res = 32'd0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset_n && bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_done: got done=1 result=%h expected no done", bus.result);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.tag, " result"}, bus.result, mon_e.res);
        check({mon_e.tag, " done_cycle"}, 32'(cyc), 32'(mon_e.at));
      end
    end
  end

  // Reference model from the ISA definition using wide arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b, output bit special);
    longint      sa, sb, ub;
    logic [63:0] ua64, ub64, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ua64 = {32'd0, a};
    ub64 = {32'd0, b};
    special = 1'b0;
    p = 64'd0;
    case (f3)
      3'd0: begin p = ua64 * ub64; return p[31:0]; end
      3'd1: begin p = sa * sb;     return p[63:32]; end
      3'd2: begin p = sa * ub;     return p[63:32]; end
      3'd3: begin p = ua64 * ub64; return p[63:32]; end
      3'd4, 3'd6: begin
        if (b == 0) begin special = 1'b1; return (f3 == 3'd4) ? 32'hFFFF_FFFF : a; end
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          special = 1'b1;
          return (f3 == 3'd4) ? 32'h8000_0000 : 32'd0;
        end
        p = (f3 == 3'd4) ? sa / sb : sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 0) begin special = 1'b1; return (f3 == 3'd5) ? 32'hFFFF_FFFF : a; end
        return (f3 == 3'd5) ? a / b : a % b;
      end
    endcase
  endfunction

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit special, input string tag);
    exp_t e;
    int   nb;
    bit   seen;
    wait_idle();
    bus.start = 1'b1;
    bus.funct3 = f3;
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    e.res = exp;
    e.at  = cyc + (special ? 0 : 33);
    e.tag = tag;
    sb_q.push_back(e);
    last_res = exp;
    nb = 0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (bus.busy) nb++;
      if (sb_q.size() == 0) begin
        seen = 1'b1;
        break;
      end
      // Scramble inputs while busy: they must be ignored.
      bus.start = 1'($urandom);
      bus.funct3 = 3'($urandom);
      bus.operand_a = $urandom;
      bus.operand_b = $urandom;
    end
    bus.start = 1'b0;
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: got no done expected done", tag);
      sb_q.delete();
    end
    check({tag, " busy_cycles"}, 32'(nb), special ? 32'd0 : 32'd33);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b, exp;
    bit          sp;

    bus.start = 1'b0;
    bus.funct3 = 3'd0;
    bus.operand_a = 32'd0;
    bus.operand_b = 32'd0;
    bus.kill = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", bus.result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    issue(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "MUL 7*-3");
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "MULH min*min");
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "MULHU max*max");
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "MULHSU -1*max");
    issue(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, "DIV -7/2");
    issue(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, "REM -7%2");
    issue(3'd5, 32'd100,       32'd7,         32'd14,        1'b0, "DIVU 100/7");
    issue(3'd7, 32'd100,       32'd7,         32'd2,         1'b0, "REMU 100%7");
    issue(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, "DIVU 5/0");
    issue(3'd7, 32'd5,         32'd0,         32'd5,         1'b1, "REMU 5%0");
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "DIV ovf");
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1, "REM ovf");

    // Kill a DIV while the iteration counter reads 10.
    wait_idle();
    bus.start = 1'b1;
    bus.funct3 = 3'd4;
    bus.operand_a = 32'd1000;
    bus.operand_b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    check("kill busy", 32'(bus.busy), 32'd0);
    check("kill result", bus.result, last_res);
    repeat (40) @(negedge clk);
    check("kill result later", bus.result, last_res);

    issue(3'd0, 32'd3, 32'd4, 32'd12, 1'b0, "MUL 3*4 after kill");

    // start together with kill in IDLE must not be accepted.
    wait_idle();
    bus.start = 1'b1;
    bus.kill = 1'b1;
    bus.funct3 = 3'd5;
    bus.operand_a = 32'd9;
    bus.operand_b = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.kill = 1'b0;
    check("kill+start busy", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    check("kill+start result", bus.result, last_res);

    // Asynchronous reset between clock edges mid-CALC.
    wait_idle();
    bus.start = 1'b1;
    bus.funct3 = 3'd0;
    bus.operand_a = 32'h1234;
    bus.operand_b = 32'h10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset busy", 32'(bus.busy), 32'd0);
    check("async reset done", 32'(bus.done), 32'd0);
    check("async reset result", bus.result, 32'd0);
    last_res = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
    issue(3'd0, 32'd2, 32'd3, 32'd6, 1'b0, "MUL 2*3 after reset");

    for (int k = 0; k < 40; k++) begin
      f3 = 3'($urandom);
      a = pick_operand();
      b = pick_operand();
      exp = model(f3, a, b, sp);
      issue(f3, a, b, exp, sp, $sformatf("rand%0d f3=%0d a=%h b=%h", k, f3, a, b));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_controller.md
# muldiv_controller

Iterative multiply/divide sequencer for the RV32M extension, sitting beside the single-cycle ALU in the execute stage. It accepts one M-extension operation at a time and runs an internal shift-add / restoring-division datapath over 32 iterations. It applies sign correction and RISC-V special-case rules, then returns a 32-bit result with a one-cycle done pulse. The pipeline stalls on `busy`.

## Interface
- No parameters; XLEN fixed at 32.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only in IDLE.
- `funct3` input 3: M-op select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `operand_a` input 32: rs1 value, captured on accept.
- `operand_b` input 32: rs2 value, captured on accept.
- `kill` input 1: synchronous abort (flush/trap).
- `busy` output 1: high in CALC and FIX.
- `done` output 1: one-cycle pulse in DONE.
- `result` output 32: final value; held until the next accept.

## Operation
- States and transitions:
  - IDLE: `start` is accepted. Special case → DONE; otherwise → CALC.
  - CALC: 32 iterations → FIX.
  - FIX: → DONE.
  - DONE: → IDLE.
- Accept (IDLE && `start` && !`kill`):
  - Latch `funct3`.
  - Compute operand signs. a is signed for MULH, MULHSU, DIV and REM. b is signed for MULH, DIV and REM. MUL is sign-agnostic and is treated as unsigned.
  - Latch absolute values.
  - Clear the 6-bit iteration counter.
- Multiply:
  - 64-bit accumulator. Each CALC cycle: if multiplier LSB is set, add the multiplicand to the upper half, then shift right 1 including the carry.
  - After 32 iterations the accumulator holds |a|·|b|.
  - FIX: if sign_a^sign_b, two's-complement-negate the 64-bit product.
  - MUL selects the low 32 bits; MULH, MULHSU and MULHU select the high 32 bits.
- Divide (restoring):
  - Each CALC cycle: shift {remainder, quotient} left 1 and trial-subtract |b| from the remainder.
  - If the subtraction does not borrow, keep the difference and set quotient LSB to 1.
  - FIX: negate the quotient if sign_a^sign_b. Negate the remainder if sign_a.
- Special cases bypass CALC/FIX (IDLE→DONE directly):
  - b = 0: DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = a.
  - Signed overflow (DIV/REM with a = 0x80000000, b = 0xFFFFFFFF): DIV result = 0x80000000, REM result = 0.
- Input rules:
  - `start` outside IDLE is ignored; no queueing.
  - Operand changes after accept have no effect.
- `kill` in any non-IDLE state:
  - Next state is IDLE; no `done` pulse.
  - `result` keeps its previous value.
  - `kill` with `start` in IDLE: request not accepted.
- Reset (async, any state):
  - State IDLE, counter 0, all internal registers 0.
  - Outputs: `busy`=0, `done`=0, `result`=0.

## Timing
- Accept at rising edge N.
- Normal path:
  - CALC occupies edges N+1 through N+32 (counter 0→31); CALC→FIX at N+32.
  - FIX→DONE at N+33.
  - `done`=1 and `result` valid in the cycle after N+33.
  - `busy` is high from after edge N until edge N+33.
  - Latency from accept to `done`: 34 cycles.
- Special-case path:
  - DONE at edge N; `done`=1 in the cycle after N.
  - `busy` never rises. Latency: 1 cycle.
- `done` falls at the next edge. `result` is stable from DONE until the next accept.
- Back-to-back: a new `start` is accepted no earlier than the cycle after DONE (IDLE). Minimum issue interval is 35 cycles normal, 2 cycles special.
- `result` is registered; no combinational path from inputs to outputs.
- `kill` sampled at edge M: state is IDLE and `busy`=0 after edge M.

## Test plan
- MUL: 7 × 0xFFFFFFFD (−3) → `result`=0xFFFFFFEB. Check `done` exactly 34 cycles after accept; `busy` high for the 33 cycles before it.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD. REM −7 % 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- Special cases, each with `done` 1 cycle after accept and `busy` never high:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- Kill and retry:
  - Start DIV, assert `kill` on CALC counter 10. Check no `done` ever, `busy`=0 the next cycle, `result` unchanged.
  - Immediately start MUL 3×4 → 12 after 34 cycles.
- Async reset: drop `reset_n` mid-CALC between clock edges. Check `busy`, `done` and `result` go to 0 immediately. After release, check a MUL 2×3 completes with result 6.
